alarm_responder: RTL and testbench

Response-side controller for the intrusion alarm. It consumes the detector's combined alarm level and per-zone sensor bits, tracks arm/disarm state, and applies an entry delay for the door zone. It drives the siren and strobe and validates a 4-bit disarm code, with lockout after repeated wrong codes. It sits downstream of the motion/door/window detector and directly drives the annunciator pins.

---
 rtl/alarm_responder.sv | 145 ++++++++++++++
 tb/tb_alarm_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_responder.sv
// rtl/alarm_responder.sv - intrusion alarm response FSM: arm/disarm, entry delay, siren/strobe, code lockout
module alarm_responder #(
    parameter int unsigned ENTRY_CYCLES   = 16,
    parameter int unsigned SIREN_HALF     = 4,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 32,
    parameter logic [3:0]  CODE           = 4'hA
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alarm_in,
    input  logic [2:0] zone_in,
    input  logic       arm_req,
    input  logic [3:0] code_in,
    input  logic       code_valid,
    output logic       siren,
    output logic       strobe,
    output logic       armed,
    output logic [2:0] state,
    output logic [2:0] zone_latched,
    output logic [1:0] bad_tries,
    output logic       locked
);
    localparam logic [2:0] S_DISARMED = 3'd0;
    localparam logic [2:0] S_ARMED    = 3'd1;
    localparam logic [2:0] S_ENTRY    = 3'd2;
    localparam logic [2:0] S_ALARM    = 3'd3;
    localparam logic [2:0] S_LOCKOUT  = 3'd4;

    localparam logic [7:0] ENTRY_LAST = 8'(ENTRY_CYCLES - 1);
    localparam logic [7:0] LOCK_LAST  = 8'(LOCKOUT_CYCLES - 1);
    localparam logic [7:0] HALF_LAST  = 8'(SIREN_HALF - 1);
    localparam logic [1:0] TRIES_MAX  = 2'(MAX_TRIES);

    logic [2:0] state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [7:0] phase_q, phase_d;
    logic       siren_q, siren_d;
    logic       strobe_q, strobe_d;
    logic       armed_q, armed_d;
    logic       locked_q, locked_d;
    logic [2:0] zone_q, zone_d;
    logic [1:0] tries_q, tries_d;

    logic       active;
    logic       code_ok;
    logic       code_bad;
    logic [1:0] tries_inc;
    logic       hit_lockout;
    logic       moved;

    assign active      = (state_q == S_ARMED) || (state_q == S_ENTRY) || (state_q == S_ALARM);
    assign code_ok     = active && code_valid && (code_in == CODE);
    assign code_bad    = active && code_valid && (code_in != CODE);
    assign tries_inc   = (tries_q == 2'd3) ? tries_q : tries_q + 2'd1;
    assign hit_lockout = code_bad && (tries_inc == TRIES_MAX);
    assign moved       = (state_d != state_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_DISARMED;
            timer_q  <= '0;
            phase_q  <= '0;
            siren_q  <= 1'b0;
            strobe_q <= 1'b0;
            armed_q  <= 1'b0;
            locked_q <= 1'b0;
            zone_q   <= '0;
            tries_q  <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            phase_q  <= phase_d;
            siren_q  <= siren_d;
            strobe_q <= strobe_d;
            armed_q  <= armed_d;
            locked_q <= locked_d;
            zone_q   <= zone_d;
            tries_q  <= tries_d;
        end
    end

    // Branch order encodes the cycle priority: correct code, lockout, non-door trigger, expiry, door trigger.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_DISARMED: if (arm_req) state_d = S_ARMED;
            S_ARMED: begin
                if (code_ok)                             state_d = S_DISARMED;
                else if (hit_lockout)                    state_d = S_LOCKOUT;
                else if (alarm_in && zone_in == 3'b010)  state_d = S_ENTRY;
                else if (alarm_in)                       state_d = S_ALARM;
            end
            S_ENTRY: begin
                if (code_ok)                                     state_d = S_DISARMED;
                else if (hit_lockout)                            state_d = S_LOCKOUT;
                else if (alarm_in && (zone_in[0] || zone_in[2])) state_d = S_ALARM;
                else if (timer_q == ENTRY_LAST)                  state_d = S_ALARM;
            end
            S_ALARM: begin
                if (code_ok)          state_d = S_DISARMED;
                else if (hit_lockout) state_d = S_LOCKOUT;
            end
            S_LOCKOUT: if (timer_q == LOCK_LAST) state_d = S_ALARM;
            default: state_d = S_DISARMED;
        endcase
    end

    always_comb begin
        timer_d = '0;
        if (!moved && (state_q == S_ENTRY || state_q == S_LOCKOUT)) timer_d = timer_q + 8'd1;

        phase_d = '0;
        if (!moved && state_q == S_ALARM && phase_q != HALF_LAST) phase_d = phase_q + 8'd1;

        siren_d = 1'b0;
        if (state_d == S_LOCKOUT)        siren_d = 1'b1;
        else if (state_d == S_ALARM) begin
            if (moved)                   siren_d = 1'b1;
            else if (phase_q == HALF_LAST) siren_d = !siren_q;
            else                         siren_d = siren_q;
        end

        strobe_d = (state_d == S_ALARM) || (state_d == S_LOCKOUT);
        armed_d  = (state_d != S_DISARMED);
        locked_d = (state_d == S_LOCKOUT);

        zone_d = zone_q;
        if (code_ok)                                        zone_d = '0;
        else if (alarm_in && (active || state_q == S_LOCKOUT)) zone_d = zone_q | zone_in;

        tries_d = tries_q;
        if (code_ok)                                          tries_d = '0;
        else if (code_bad)                                    tries_d = tries_inc;
        else if (state_q == S_LOCKOUT && state_d == S_ALARM)  tries_d = '0;
    end

    assign siren        = siren_q;
    assign strobe       = strobe_q;
    assign armed        = armed_q;
    assign locked       = locked_q;
    assign state        = state_q;
    assign zone_latched = zone_q;
    assign bad_tries    = tries_q;
endmodule

// File: tb/tb_alarm_responder.sv
// tb/tb_alarm_responder.sv - directed bench with cycle-level behavioural model for alarm_responder
module tb_alarm_responder;
    localparam int ENTRY = 16;
    localparam int HALF  = 4;
    localparam int TRIES = 3;
    localparam int LOCK  = 32;

    logic       clk;
    logic       rst;
    logic       alarm_in;
    logic [2:0] zone_in;
    logic       arm_req;
    logic [3:0] code_in;
    logic       code_valid;
    logic       siren, strobe, armed, locked;
    logic [2:0] state, zone_latched;
    logic [1:0] bad_tries;

    int total = 0;
    int bad   = 0;
    int siren_hits = 0;
    bit run_chk = 0;
    logic [7:0] pat;

    int m_state = 0;
    int m_n     = 0;
    int m_zone  = 0;
    int m_tries = 0;

    alarm_responder #(
        .ENTRY_CYCLES(ENTRY), .SIREN_HALF(HALF), .MAX_TRIES(TRIES),
        .LOCKOUT_CYCLES(LOCK), .CODE(4'hA)
    ) dut (
        .clk(clk), .rst(rst), .alarm_in(alarm_in), .zone_in(zone_in),
        .arm_req(arm_req), .code_in(code_in), .code_valid(code_valid),
        .siren(siren), .strobe(strobe), .armed(armed), .state(state),
        .zone_latched(zone_latched), .bad_tries(bad_tries), .locked(locked)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: state plus "edges spent in this state"; siren derived from elapsed ALARM time.
    always @(posedge clk) begin
        int nxt;
        bit ok, wrong;
        if (rst) begin
            m_state = 0; m_n = 0; m_zone = 0; m_tries = 0;
        end else begin
            nxt   = m_state;
            ok    = code_valid && code_in == 4'hA;
            wrong = code_valid && code_in != 4'hA;
            if (m_state == 0) begin
                if (arm_req) nxt = 1;
            end else if (m_state == 4) begin
                if (alarm_in) m_zone = m_zone | int'(zone_in);
                if (m_n + 1 == LOCK) begin nxt = 3; m_tries = 0; end
            end else if (ok) begin
                nxt = 0; m_tries = 0; m_zone = 0;
            end else begin
                if (alarm_in) m_zone = m_zone | int'(zone_in);
                if (wrong) m_tries = (m_tries + 1 > 3) ? 3 : m_tries + 1;
                if (wrong && m_tries == TRIES) nxt = 4;
                else if (m_state == 1 && alarm_in) nxt = (zone_in == 3'b010) ? 2 : 3;
                else if (m_state == 2 && alarm_in && (zone_in[0] || zone_in[2])) nxt = 3;
                else if (m_state == 2 && m_n + 1 == ENTRY) nxt = 3;
            end
            m_n = (nxt != m_state) ? 0 : m_n + 1;
            m_state = nxt;
        end
    end

    always @(negedge clk) begin
        if (run_chk) begin
            int exp_siren;
            exp_siren = (m_state == 4) ? 1 : (m_state == 3) ? int'(((m_n / HALF) % 2) == 0) : 0;
            chk("m_state",  state,        m_state);
            chk("m_siren",  siren,        exp_siren);
            chk("m_strobe", strobe,       int'(m_state == 3 || m_state == 4));
            chk("m_armed",  armed,        int'(m_state != 0));
            chk("m_locked", locked,       int'(m_state == 4));
            chk("m_zone",   zone_latched, m_zone);
            chk("m_tries",  bad_tries,    m_tries);
            if (siren === 1'b1) siren_hits++;
        end
    end

    task automatic drive(input logic a, input logic [2:0] z, input logic arm,
                         input logic cv, input logic [3:0] c);
        alarm_in = a; zone_in = z; arm_req = arm; code_valid = cv; code_in = c;
        @(posedge clk); #2;
        alarm_in = 0; zone_in = 0; arm_req = 0; code_valid = 0; code_in = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 3'b000, 0, 0, 4'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; alarm_in = 0; zone_in = 0; arm_req = 0; code_valid = 0; code_in = 0;
        @(posedge clk); #2; run_chk = 1;
        @(posedge clk); #2; rst = 0;
        chk("rst_state", state, 0);
        chk("rst_siren", siren, 0);
        chk("rst_tries", bad_tries, 0);

        drive(0, 3'b000, 1, 0, 4'h0);
        chk("arm_state", state, 1);
        chk("arm_armed", armed, 1);
        chk("arm_siren", siren, 0);
        drive(0, 3'b000, 1, 0, 4'h0);
        chk("rearm_state", state, 1);

        siren_hits = 0;
        drive(1, 3'b010, 0, 0, 4'h0);
        chk("door_entry", state, 2);
        chk("door_zone", zone_latched, 3'b010);
        idle(9);
        chk("entry_wait", state, 2);
        drive(0, 3'b000, 0, 1, 4'hA);
        chk("entry_disarm", state, 0);
        chk("entry_zone_clr", zone_latched, 0);
        chk("entry_no_siren", siren_hits, 0);

        drive(0, 3'b000, 1, 0, 4'h0);
        drive(1, 3'b010, 0, 0, 4'h0);
        idle(15);
        chk("expiry_minus1", state, 2);
        idle(1);
        chk("expiry_alarm", state, 3);
        chk("expiry_strobe", strobe, 1);
        pat = '0;
        for (int i = 0; i < 8; i++) begin
            pat[7-i] = siren;
            if (i < 7) idle(1);
        end
        chk("siren_pattern", pat, 8'hF0);
        drive(0, 3'b000, 0, 1, 4'hA);
        chk("alarm_disarm", state, 0);

        drive(0, 3'b000, 1, 0, 4'h0);
        drive(1, 3'b010, 0, 0, 4'h0);
        idle(15);
        drive(0, 3'b000, 0, 1, 4'hA);
        chk("code_at_expiry", state, 0);

        drive(0, 3'b000, 1, 0, 4'h0);
        drive(1, 3'b010, 0, 0, 4'h0);
        idle(3);
        drive(1, 3'b001, 0, 0, 4'h0);
        chk("motion_alarm", state, 3);
        chk("motion_zone", zone_latched, 3'b011);
        drive(0, 3'b000, 0, 1, 4'hA);

        drive(0, 3'b000, 1, 0, 4'h0);
        drive(1, 3'b100, 0, 0, 4'h0);
        chk("window_alarm", state, 3);
        drive(0, 3'b000, 0, 1, 4'h3);
        chk("tries_1", bad_tries, 1);
        idle(2);
        drive(0, 3'b000, 0, 1, 4'h3);
        chk("tries_2", bad_tries, 2);
        chk("tries_2_state", state, 3);
        drive(0, 3'b000, 0, 1, 4'h3);
        chk("lockout_state", state, 4);
        chk("lockout_locked", locked, 1);
        chk("lockout_siren", siren, 1);
        chk("lockout_tries", bad_tries, 3);
        drive(0, 3'b000, 0, 1, 4'hA);
        chk("lockout_ignores_code", state, 4);
        idle(29);
        chk("lockout_siren_steady", siren, 1);
        idle(1);
        chk("lockout_last", state, 4);
        idle(1);
        chk("lockout_exit", state, 3);
        chk("lockout_exit_tries", bad_tries, 0);
        chk("lockout_exit_siren", siren, 1);
        drive(0, 3'b000, 0, 1, 4'hA);

        drive(0, 3'b000, 1, 0, 4'h0);
        drive(1, 3'b100, 0, 1, 4'hA);
        chk("simul_state", state, 0);
        chk("simul_zone", zone_latched, 0);

        drive(0, 3'b000, 1, 0, 4'h0);
        drive(1, 3'b100, 0, 0, 4'h0);
        for (int i = 0; i < 3; i++) drive(0, 3'b000, 0, 1, 4'h5);
        chk("rst_lock_pre", state, 4);
        idle(5);
        rst = 1;
        @(posedge clk); #2;
        rst = 0;
        chk("rst2_state", state, 0);
        chk("rst2_locked", locked, 0);
        chk("rst2_siren", siren, 0);
        chk("rst2_strobe", strobe, 0);
        chk("rst2_armed", armed, 0);
        chk("rst2_zone", zone_latched, 0);
        chk("rst2_tries", bad_tries, 0);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
